// File: rtl/player_pkg.sv
// Shared types and screen geometry for the player motion path.
package player_pkg;
   localparam int POS_W    = 10;
   localparam int VEL_W    = 8;
   localparam int SUM_W    = 11;
   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam int GROUND_Y = 400;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WALK   = 3'd1,
      CROUCH = 3'd2,
      JUMP   = 3'd3,
      FALL   = 3'd4
   } motion_state_t;
endpackage

// File: rtl/axis_clamp.sv
// Signed base+delta, saturated to [lo, hi], then narrowed to the output width.
module axis_clamp #(
   parameter int W  = 11,
   parameter int OW = 10
) (
   input  logic signed [W-1:0]  base,
   input  logic signed [W-1:0]  delta,
   input  logic signed [W-1:0]  lo,
   input  logic signed [W-1:0]  hi,
   output logic        [OW-1:0] clamped
);
   logic signed [W-1:0] sum;
   logic signed [W-1:0] sat;

   always_comb begin
      sum = base + delta;
      sat = sum;
      if (sum < lo) sat = lo;
      else if (sum > hi) sat = hi;
      clamped = OW'(sat);
   end
endmodule

// File: rtl/player_motion_controller.sv
// Player walk/crouch/jump/fall sequencer; all state advances on frame_tick only.
module player_motion_controller
   import player_pkg::*;
#(
   parameter int X_MIN    = 0,
   parameter int X_MAX    = 623,
   parameter int X_START  = 320,
   parameter int Y_GROUND = GROUND_Y,
   parameter int X_STEP   = 2,
   parameter int JUMP_VEL = 12,
   parameter int GRAVITY  = 1,
   parameter int MAX_FALL = 8
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             frame_tick,
   input  logic             w_on,
   input  logic             s_on,
   input  logic             a_on,
   input  logic             d_on,
   output logic [POS_W-1:0] pos_x,
   output logic [POS_W-1:0] pos_y,
   output motion_state_t    state,
   output logic             facing_left,
   output logic             airborne
);
   localparam logic signed [VEL_W-1:0] MAX_F  = VEL_W'(MAX_FALL);
   localparam logic signed [VEL_W-1:0] GRAV   = VEL_W'(GRAVITY);
   localparam logic signed [VEL_W-1:0] JUMP_V = VEL_W'(-JUMP_VEL);
   localparam logic signed [SUM_W-1:0] YG     = SUM_W'(Y_GROUND);

   logic signed [VEL_W-1:0] vel_y, vel_next;
   logic                    w_prev;
   logic                    dir_l, dir_r, dir_any, jump_edge;
   logic signed [SUM_W-1:0] dx, dy, ny;
   logic        [POS_W-1:0] nx_c, ny_c;

   always_comb begin
      dir_l     = a_on & ~d_on;
      dir_r     = d_on & ~a_on;
      dir_any   = dir_l | dir_r;
      jump_edge = w_on & ~w_prev;
      dx        = dir_r ? SUM_W'(X_STEP) : (dir_l ? SUM_W'(-X_STEP) : '0);
      dy        = {{(SUM_W-VEL_W){vel_y[VEL_W-1]}}, vel_y};
      ny        = $signed({1'b0, pos_y}) + dy;
      vel_next  = (vel_y >= MAX_F) ? MAX_F : vel_y + GRAV;
   end

   axis_clamp #(.W(SUM_W), .OW(POS_W)) u_x_clamp (
      .base    ($signed({1'b0, pos_x})),
      .delta   (dx),
      .lo      (SUM_W'(X_MIN)),
      .hi      (SUM_W'(X_MAX)),
      .clamped (nx_c)
   );

   // Y is bounded by the top of the screen and the ground line.
   axis_clamp #(.W(SUM_W), .OW(POS_W)) u_y_clamp (
      .base    ($signed({1'b0, pos_y})),
      .delta   (dy),
      .lo      ('0),
      .hi      (YG),
      .clamped (ny_c)
   );

   assign airborne = (state == JUMP) | (state == FALL);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         pos_x       <= POS_W'(X_START);
         pos_y       <= POS_W'(Y_GROUND);
         vel_y       <= '0;
         state       <= IDLE;
         facing_left <= 1'b0;
         w_prev      <= 1'b0;
      end else if (frame_tick) begin
         // w_prev tracks every tick so an edge seen while crouched is lost.
         w_prev <= w_on;
         if (state != CROUCH && dir_any) begin
            pos_x       <= nx_c;
            facing_left <= dir_l;
         end
         case (state)
            IDLE, WALK: begin
               if (jump_edge && !s_on) begin
                  state <= JUMP;
                  vel_y <= JUMP_V;
               end else if (s_on)  state <= CROUCH;
               else if (dir_any)   state <= WALK;
               else                state <= IDLE;
            end
            CROUCH: if (!s_on) state <= IDLE;
            JUMP: begin
               if (ny < 0) begin
                  pos_y <= '0;
                  vel_y <= '0;
                  state <= FALL;
               end else begin
                  pos_y <= ny_c;
                  vel_y <= vel_next;
                  if (vel_next >= 0) state <= FALL;
               end
            end
            FALL: begin
               if (ny >= YG) begin
                  pos_y <= POS_W'(Y_GROUND);
                  vel_y <= '0;
                  state <= dir_any ? WALK : IDLE;
               end else if (ny < 0) begin
                  pos_y <= '0;
                  vel_y <= '0;
               end else begin
                  pos_y <= ny_c;
                  vel_y <= vel_next;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_player_motion_controller.sv
// Directed bench for player_motion_controller with hand-computed expectations.
module tb_player_motion_controller;
   import player_pkg::*;

   logic             Clk = 1'b0, Reset = 1'b1, frame_tick = 1'b0;
   logic             w_on = 1'b0, s_on = 1'b0, a_on = 1'b0, d_on = 1'b0;
   logic [POS_W-1:0] pos_x, pos_y;
   motion_state_t    state;
   logic             facing_left, airborne;

   int n_cmp = 0;
   int n_err = 0;

   player_motion_controller dut (
      .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
      .w_on(w_on), .s_on(s_on), .a_on(a_on), .d_on(d_on),
      .pos_x(pos_x), .pos_y(pos_y), .state(state),
      .facing_left(facing_left), .airborne(airborne)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge Clk) frame_tick = 1'b1;
         @(negedge Clk) frame_tick = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge Clk) Reset = 1'b1;
      @(negedge Clk) Reset = 1'b0;
   endtask

   int max_y;
   int y_f14;
   int stable;

   initial begin
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      chk("rst_x", pos_x, 320);
      chk("rst_y", pos_y, 400);
      chk("rst_state", state, IDLE);
      chk("rst_face", facing_left, 0);
      chk("rst_air", airborne, 0);

      tick(3);
      chk("idle_x", pos_x, 320);
      chk("idle_y", pos_y, 400);
      chk("idle_state", state, IDLE);
      chk("idle_air", airborne, 0);

      d_on = 1'b1;
      tick(5);
      chk("walk_x", pos_x, 330);
      chk("walk_state", state, WALK);
      chk("walk_face", facing_left, 0);
      a_on = 1'b1;
      tick(1);
      chk("both_x", pos_x, 330);
      chk("both_state", state, IDLE);
      d_on = 1'b0;

      do_reset();
      tick(1);
      chk("left1_x", pos_x, 318);
      tick(199);
      chk("left_sat_x", pos_x, 0);
      chk("left_face", facing_left, 1);
      a_on = 1'b0;

      // single w pulse, vertical profile
      do_reset();
      w_on = 1'b1;
      tick(1);
      w_on = 1'b0;
      chk("jump_state", state, JUMP);
      chk("jump_vel", int'(dut.vel_y), -12);
      chk("jump_y", pos_y, 400);
      chk("jump_air", airborne, 1);
      tick(12);
      chk("apex_y", pos_y, 322);
      chk("apex_state", state, FALL);
      chk("apex_vel", int'(dut.vel_y), 0);
      max_y = 0;
      y_f14 = 0;
      for (int i = 0; i < 15; i++) begin
         tick(1);
         if (int'(pos_y) > max_y) max_y = int'(pos_y);
         if (i == 13) y_f14 = int'(pos_y);
      end
      chk("fall14_y", y_f14, 398);
      chk("land_y", pos_y, 400);
      chk("land_state", state, IDLE);
      chk("land_air", airborne, 0);
      chk("max_y", max_y, 400);

      w_on = 1'b1;
      tick(28);
      chk("hold_land_state", state, IDLE);
      tick(5);
      chk("hold_no_rejump", state, IDLE);
      chk("hold_y", pos_y, 400);
      w_on = 1'b0;
      tick(1);

      s_on = 1'b1;
      tick(1);
      chk("crouch_state", state, CROUCH);
      w_on = 1'b1;
      d_on = 1'b1;
      tick(1);
      chk("crouch_hold", state, CROUCH);
      chk("crouch_x", pos_x, 320);
      chk("crouch_y", pos_y, 400);
      d_on = 1'b0;
      s_on = 1'b0;
      tick(1);
      chk("uncrouch_state", state, IDLE);
      tick(1);
      chk("edge_consumed", state, IDLE);
      w_on = 1'b0;
      tick(1);

      // airborne steering, then reset mid-fall
      d_on = 1'b1;
      w_on = 1'b1;
      tick(1);
      w_on = 1'b0;
      chk("air_jump_x", pos_x, 322);
      tick(20);
      chk("mid_y", pos_y, 350);
      chk("mid_x", pos_x, 362);
      chk("mid_state", state, FALL);
      do_reset();
      chk("midrst_y", pos_y, 400);
      chk("midrst_x", pos_x, 320);
      chk("midrst_state", state, IDLE);
      chk("midrst_air", airborne, 0);

      tick(3);
      chk("pre_coinc_x", pos_x, 326);
      @(negedge Clk) begin Reset = 1'b1; frame_tick = 1'b1; end
      @(negedge Clk) begin Reset = 1'b0; frame_tick = 1'b0; end
      chk("coinc_x", pos_x, 320);
      chk("coinc_state", state, IDLE);

      tick(2);
      stable = 1;
      for (int i = 0; i < 100; i++) begin
         @(negedge Clk);
         if (pos_x != 10'd324 || pos_y != 10'd400 || state != WALK) stable = 0;
      end
      chk("stall_stable", stable, 1);
      chk("stall_x", pos_x, 324);

      w_on = 1'b1;
      tick(1);
      w_on = 1'b0;
      tick(27);
      chk("land_walk_state", state, WALK);
      chk("land_walk_x", pos_x, 380);
      chk("land_walk_y", pos_y, 400);
      d_on = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/player_motion_controller.md
Name: player_motion_controller

Overview:
- Sequences the player sprite from the decoded w/s/a/d key flags: walk, crouch, jump and gravity fall.
- Advances one step per frame tick.
- Sits between the keycode decode stage and the sprite/collision drawing logic.
- Owns the player X/Y position, vertical velocity and motion state.

Parameters:
- X_MIN, 0, leftmost legal pos_x
- X_MAX, 623, rightmost legal pos_x (sprite left edge)
- X_START, 320, pos_x after reset
- Y_GROUND, 400, pos_y when standing on ground; also reset pos_y
- X_STEP, 2, horizontal pixels per frame while walking
- JUMP_VEL, 12, initial upward speed (pixels/frame)
- GRAVITY, 1, velocity increment per airborne frame
- MAX_FALL, 8, downward speed saturation

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-Clk pulse per video frame
- w_on  in  1  jump key/button held
- s_on  in  1  crouch key held
- a_on  in  1  left key/button held
- d_on  in  1  right key/button held
- pos_x  out  10  player X, unsigned
- pos_y  out  10  player Y, unsigned, screen-down positive
- state  out  3  motion state encoding (package enum)
- facing_left  out  1  last horizontal direction, 1 = left
- airborne  out  1  state is JUMP or FALL

Behaviour:
- Reset values:
  - pos_x = X_START, pos_y = Y_GROUND, vel_y = 0
  - state = IDLE, facing_left = 0, w_prev = 0
- Reset has priority over frame_tick in the same cycle.
- Reset mid-jump returns the player to ground at the start position.
- All registers change only on Clk edges where frame_tick = 1. Between ticks all outputs hold.
- Inputs are sampled on the tick. New values are visible the cycle after the tick, so latency is 1 Clk.
- w_prev <= w_on on every tick. jump_edge = w_on & ~w_prev. Holding w does not re-jump.
- Horizontal direction:
  - dir = left if a_on & ~d_on; right if d_on & ~a_on; none otherwise, including both pressed.
  - Applies in IDLE, WALK, JUMP and FALL. Ignored in CROUCH.
  - pos_x moves by X_STEP.
  - Compute in 11-bit signed arithmetic, then clamp to [X_MIN, X_MAX]. pos_x never wraps.
  - facing_left updates whenever dir is not none, including while airborne.
- States:
  - IDLE / WALK, grounded:
    - jump_edge & ~s_on -> JUMP, vel_y <= -JUMP_VEL, pos_y unchanged on this tick.
    - else s_on -> CROUCH.
    - else dir not none -> WALK.
    - else -> IDLE.
  - CROUCH:
    - ~s_on -> IDLE.
    - Jump and horizontal motion are blocked.
    - A w edge that occurs while crouched is consumed, not latched.
  - JUMP and FALL, airborne, every tick:
    - ny = pos_y + vel_y.
    - vel_y <= min(vel_y + GRAVITY, MAX_FALL).
    - If ny < 0, clamp pos_y to 0 and set vel_y <= 0.
    - In JUMP: when the updated vel_y >= 0 -> FALL.
    - In FALL: if ny >= Y_GROUND -> pos_y <= Y_GROUND, vel_y <= 0, next state = WALK if dir not none, else IDLE. Otherwise pos_y <= ny.
    - Landing and the horizontal step happen on the same tick.
- Width rules:
  - vel_y is 8-bit signed.
  - Vertical sums are 11-bit signed.
  - Outputs are truncated only after clamping.
- airborne = (state == JUMP) | (state == FALL), decoded from registered state, so there is no extra latency.

Decomposition:
- Package player_pkg:
  - motion_state_t enum {IDLE, WALK, CROUCH, JUMP, FALL}
  - POS_W = 10, VEL_W = 8
  - Shared screen constants: 640x480, ground line
- One sub-module, axis_clamp: signed add plus saturate to [min, max]. Instantiated for X; Y also uses it for the ground/top clamp.
- Everything else stays in a single FSM plus datapath.

Test Plan:
1. Reset, then 3 ticks idle -> pos_x = 320, pos_y = 400, state = IDLE, airborne = 0.
2. d_on held for 5 ticks -> pos_x = 330, state = WALK, facing_left = 0. Then a_on & d_on together -> pos_x holds at 330 and state = IDLE.
3. a_on held from pos_x = 320 for 200 ticks -> pos_x saturates at 0 with no wrap, facing_left = 1.
4. w pulse for one tick:
   - Tick 1: state = JUMP, vel_y = -12.
   - After 12 more ticks: pos_y = 322, state = FALL.
   - Lands with pos_y = 400, state = IDLE, and never exceeds 400.
   - w held throughout -> only one jump.
5. s_on held with w and d pulses -> state = CROUCH, pos_x and pos_y unchanged. Release s -> IDLE next tick.
6. Edge cases:
   - Reset asserted mid-jump at pos_y = 350 -> next cycle pos_y = 400, pos_x = 320, state = IDLE.
   - Reset coincident with frame_tick -> reset wins.
   - frame_tick low for 100 Clk -> outputs stable.
